brz_pull_fetch_sync: RTL and testbench
======================================

Name: brz_pull_fetch_sync

Overview:
- Clocked initiator for the requester end of a Balsa four-phase bundled-data pull channel (inp_0r/inp_0a/inp_0d).
- Issues requests, synchronises the asynchronous acknowledge and captures data while ack is high.
- Extracts a bit slice from the captured word and offers it to synchronous logic over a valid/ready interface.
- Bridges slice-style async pull components into the clocked test/integration fabric.

Parameters:
- DATA_W, 18, width of inp_0d.
- LOW_BIT, 1, LSB index of the extracted slice.
- SLICE_W, 16, width of out_data; LOW_BIT+SLICE_W <= DATA_W (elaboration-time check).
- SYNC_STAGES, 2, flops in the ack synchroniser; legal range 2..4.
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pull_en  in  1  permits new fetch cycles while high
- inp_0r  out  1  pull request to responder
- inp_0a  in  1  acknowledge from responder (asynchronous)
- inp_0d  in  DATA_W  bundled data, valid while inp_0a high
- out_valid  out  1  slice held in output register
- out_ready  in  1  consumer accepts slice
- out_data  out  SLICE_W  inp_0d[LOW_BIT+SLICE_W-1:LOW_BIT] as captured
- busy  out  1  handshake not at rest (inp_0r high or synchronised ack high)
- xfer_cnt  out  CNT_W  completed captures, wraps modulo 2^CNT_W
- err  out  1  sticky protocol/timeout error (see Optional Feature)

Behaviour:
- Reset values: inp_0r=0, out_valid=0, out_data=0, xfer_cnt=0, err=0, state=IDLE, synchroniser=0.
- ack_s is inp_0a after SYNC_STAGES flops. Logic never uses inp_0a directly.
- IDLE:
  - Go to REQ and set inp_0r=1 when pull_en=1, ack_s=0, and the output buffer is free next cycle.
  - The buffer is free next cycle when out_valid=0, or when out_valid&out_ready this cycle.
- REQ: hold inp_0r=1. When ack_s=1:
  - capture inp_0d slice into out_data.
  - set out_valid=1 and increment xfer_cnt.
  - drop inp_0r=0 and go to RTZ, all in the same edge.
- RTZ: inp_0r=0. When ack_s=0, go to IDLE.
- Capture happens only in REQ on the first cycle ack_s=1; data is stable because the ack is still high.
- Output buffer:
  - out_valid clears on out_valid&out_ready unless a capture occurs in the same cycle; capture wins and out_valid stays 1.
  - out_data is stable while out_valid=1 and out_ready=0.
- Minimum cycle, clk edges from REQ entry back to IDLE: SYNC_STAGES+1 (ack rise) + SYNC_STAGES+1 (ack fall), plus responder delay.
- Throughput is at most one word per full four-phase cycle. There is no prefetch beyond the single buffer.
- pull_en deasserted mid-handshake: the current handshake completes normally and the captured word is delivered. No new request is issued.
- ack_s=1 observed in IDLE is a protocol violation. Set err=1 and stay in IDLE until ack_s=0.
- Reset asserted mid-handshake: inp_0r drops asynchronously and the buffer is discarded. After release, the FSM waits in IDLE until ack_s=0 before the next request.
- busy = inp_0r | ack_s.

Optional Feature:
- Macro BRZ_PULL_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 1023) and a counter that resets on every state change.
  - If REQ or RTZ persists for TIMEOUT_CYC cycles, set err=1 (sticky until reset).
  - Force inp_0r=0 and go to RTZ. No data is captured from the aborted request.
- Undefined: no counter. err is driven only by the IDLE protocol violation. The FSM waits indefinitely.

Decomposition:
- Package brz_sync_pkg holds:
  - the state enum (IDLE, REQ, RTZ);
  - default width constants (DATA_W=18, SLICE_W=16, LOW_BIT=1);
  - the SYNC_STAGES legal range.
- One sub-module, brz_sync_bit: a SYNC_STAGES-deep flop chain with asynchronous active-low reset, used for inp_0a.
- FSM, buffer and counter stay in the top module.

Test Plan:
- Basic fetch:
  - Stimulus: pull_en=1, out_ready=1; responder acks 3 cycles after request with inp_0d=18'h2A5A5.
  - Expect: out_data=16'h52D2 and out_valid for one cycle; xfer_cnt=1; inp_0r returns to 0 before the next request.
- Backpressure:
  - Stimulus: out_ready=0, responder always acks.
  - Expect: exactly one capture; inp_0r stays 0 after RTZ; out_data stable.
  - Then raise out_ready for one cycle. Expect the next request issues in that same cycle.
- Simultaneous consume and capture:
  - Stimulus: out_ready=1 on the capture edge.
  - Expect: out_valid stays 1 with the new data; no word lost; xfer_cnt increments each word.
- Wrap and pull_en drop:
  - Stimulus: 256 transfers; pull_en cleared while in REQ.
  - Expect: xfer_cnt wraps to 0; the in-flight word is delivered; no further inp_0r.
- Violations:
  - Stimulus: inp_0a high while IDLE. Expect err=1 and no request until inp_0a falls.
  - Stimulus: rst_n low during REQ. Expect inp_0r=0 immediately and out_valid=0.
- BRZ_PULL_TIMEOUT_EN build:
  - Stimulus: responder never acks; TIMEOUT_CYC=15.
  - Expect: err=1 after 15 cycles in REQ; inp_0r=0; out_valid remains 0.

Source files
------------

// File: rtl/brz_sync_pkg.sv
// Shared types and default widths for the Balsa pull-channel fetch bridge.
package brz_sync_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RTZ  = 2'd2
  } brz_state_e;

  localparam int unsigned DATA_W_DEF      = 18;
  localparam int unsigned SLICE_W_DEF     = 16;
  localparam int unsigned LOW_BIT_DEF     = 1;
  localparam int unsigned CNT_W_DEF       = 8;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/brz_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level (used for the pull acknowledge).
module brz_sync_bit
  import brz_sync_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  if ((STAGES < SYNC_STAGES_MIN) || (STAGES > SYNC_STAGES_MAX)) begin : g_bad_stages
    $error("brz_sync_bit: STAGES outside legal synchroniser depth");
  end

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/brz_pull_fetch_sync.sv
// Clocked requester for a four-phase Balsa pull channel; delivers a data slice over valid/ready.
// Optional request/return-to-zero timeout is enabled with BRZ_PULL_TIMEOUT_EN.
module brz_pull_fetch_sync
  import brz_sync_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned LOW_BIT     = LOW_BIT_DEF,
  parameter int unsigned SLICE_W     = SLICE_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int unsigned CNT_W       = CNT_W_DEF
`ifdef BRZ_PULL_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 1023
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pull_en,
  output logic               inp_0r,
  input  logic               inp_0a,
  input  logic [DATA_W-1:0]  inp_0d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SLICE_W-1:0] out_data,
  output logic               busy,
  output logic [CNT_W-1:0]   xfer_cnt,
  output logic               err
);

  if ((LOW_BIT + SLICE_W) > DATA_W) begin : g_bad_slice
    $error("brz_pull_fetch_sync: slice exceeds data width");
  end

  brz_state_e         r_state;
  brz_state_e         w_next_state;
  logic               w_ack_s;
  logic               w_capture;
  logic               w_err_set;
  logic               w_buf_free;
  logic               w_tmo;
  logic [SLICE_W-1:0] w_slice;
  logic               w_unused_d;

  logic               r_inp_0r;
  logic               r_out_valid;
  logic [SLICE_W-1:0] r_out_data;
  logic [CNT_W-1:0]   r_xfer_cnt;
  logic               r_err;

  brz_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (inp_0a),
    .o_q   (w_ack_s)
  );

  assign w_slice    = inp_0d[LOW_BIT +: SLICE_W];
  assign w_unused_d = ^inp_0d;
  // Buffer frees at the coming edge if empty now or being consumed this cycle.
  assign w_buf_free = !r_out_valid || out_ready;

`ifdef BRZ_PULL_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo_cnt;

  assign w_tmo = (r_state != IDLE) && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Dwell counter: restarts on any state change or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if ((w_next_state != r_state) || w_tmo || (r_state == IDLE)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      IDLE: begin
        // A raised ack with no request outstanding is a responder fault.
        if (w_ack_s) begin
          w_err_set = 1'b1;
        end else if (pull_en && w_buf_free) begin
          w_next_state = REQ;
        end
      end
      REQ: begin
        if (w_ack_s) begin
          w_capture    = 1'b1;
          w_next_state = RTZ;
        end else if (w_tmo) begin
          w_err_set    = 1'b1;
          w_next_state = RTZ;
        end
      end
      RTZ: begin
        if (!w_ack_s) begin
          w_next_state = IDLE;
        end else if (w_tmo) begin
          w_err_set = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request, output buffer, transfer count and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inp_0r    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_xfer_cnt  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_inp_0r <= (w_next_state == REQ);
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_capture) begin
        r_out_data  <= w_slice;
        r_out_valid <= 1'b1;
        r_xfer_cnt  <= r_xfer_cnt + CNT_W'(1);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign inp_0r    = r_inp_0r;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign xfer_cnt  = r_xfer_cnt;
  assign err       = r_err;
  assign busy      = r_inp_0r | w_ack_s;

endmodule

// File: tb/tb_brz_pull_fetch_sync.sv
// Directed bench for brz_pull_fetch_sync; the timeout sequence runs when BRZ_PULL_TIMEOUT_EN is defined.
module tb_brz_pull_fetch_sync;

  localparam int unsigned DW = 18;
  localparam int unsigned SW = 16;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [3:0]    dly;
    logic [SW-1:0] exp_d;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pull_en = 1'b0;
  logic          inp_0a = 1'b0;
  logic [DW-1:0] inp_0d = '0;
  logic          out_ready = 1'b0;
  logic          inp_0r;
  logic          out_valid;
  logic          busy;
  logic          err;
  logic [SW-1:0] out_data;
  logic [CW-1:0] xfer_cnt;

  int            n_vec = 0;
  int            n_bad = 0;
  int            n_xfer = 0;
  logic [CW-1:0] exp_cnt = '0;
  vec_t          tbl [8];

  always #5 clk = ~clk;

  brz_pull_fetch_sync #(
    .DATA_W      (DW),
    .LOW_BIT     (1),
    .SLICE_W     (SW),
    .CNT_W       (CW)
`ifdef BRZ_PULL_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (15)
`endif
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pull_en   (pull_en),
    .inp_0r    (inp_0r),
    .inp_0a    (inp_0a),
    .inp_0d    (inp_0d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .err       (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bounded wait, on falling edges, for inp_0r to reach the wanted level.
  task automatic wait_req(input logic want, input string name);
    int i;
    i = 0;
    while ((inp_0r !== want) && (i < 200)) begin
      @(negedge clk);
      i++;
    end
    n_vec++;
    if (inp_0r !== want) begin
      n_bad++;
      $display("FAIL %s: inp_0r stuck at %b, expected %b", name, inp_0r, want);
    end
  endtask

  // One responder handshake: ack dly cycles after request, check the captured slice.
  task automatic fetch(input logic [DW-1:0] d, input int dly, input logic [SW-1:0] exp_d,
                       input logic drop_en, input string name);
    wait_req(1'b1, {name, " req"});
    if (drop_en) pull_en = 1'b0;
    repeat (dly) @(negedge clk);
    inp_0d = d;
    inp_0a = 1'b1;
    wait_req(1'b0, {name, " req drop"});
    exp_cnt++;
    n_xfer++;
    check({name, " data"}, 32'(out_data), 32'(exp_d));
    check({name, " valid"}, 32'(out_valid), 32'd1);
    check({name, " cnt"}, 32'(xfer_cnt), 32'(exp_cnt));
    inp_0a = 1'b0;
    inp_0d = ~d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [DW-1:0] rd;

    tbl[0] = '{18'h2A5A5, 4'd3, 16'h52D2};
    tbl[1] = '{18'h3FFFF, 4'd0, 16'hFFFF};
    tbl[2] = '{18'h00001, 4'd1, 16'h0000};
    tbl[3] = '{18'h20000, 4'd2, 16'h0000};
    tbl[4] = '{18'h12345, 4'd5, 16'h91A2};
    tbl[5] = '{18'h1FFFE, 4'd0, 16'hFFFF};
    tbl[6] = '{18'h15555, 4'd4, 16'hAAAA};
    tbl[7] = '{18'h0AAAA, 4'd1, 16'h5555};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset inp_0r", 32'(inp_0r), 32'd0);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset data", 32'(out_data), 32'd0);
    check("reset cnt", 32'(xfer_cnt), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    pull_en   = 1'b1;
    out_ready = 1'b1;

    // Table vectors: consumer always ready, so each word is valid for one cycle.
    for (int i = 0; i < 8; i++) begin
      fetch(tbl[i].d, int'(tbl[i].dly), tbl[i].exp_d, 1'b0, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d valid clears", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: one capture, then no request while the buffer is held.
    out_ready = 1'b0;
    fetch(18'h0ABCD, 1, 16'h55E6, 1'b0, "bp");
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (inp_0r !== 1'b0) cnt++;
    end
    check("bp no req", 32'(cnt), 32'd0);
    check("bp data held", 32'(out_data), 32'h55E6);
    check("bp valid held", 32'(out_valid), 32'd1);
    check("bp cnt held", 32'(xfer_cnt), 32'(exp_cnt));
    out_ready = 1'b1;
    @(negedge clk);
    check("bp req same cycle", 32'(inp_0r), 32'd1);
    check("bp consumed", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    fetch(18'h12345, 0, 16'h91A2, 1'b0, "bp2");
    out_ready = 1'b1;

    // Ack raised while idle: sticky error and no request until it falls.
    pull_en = 1'b0;
    repeat (6) @(negedge clk);
    inp_0a = 1'b1;
    repeat (4) @(negedge clk);
    check("viol err", 32'(err), 32'd1);
    pull_en = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (inp_0r !== 1'b0) cnt++;
    end
    check("viol no req", 32'(cnt), 32'd0);
    inp_0a = 1'b0;
    fetch(18'h3FFFF, 1, 16'hFFFF, 1'b0, "viol");
    check("viol err sticky", 32'(err), 32'd1);

    // Bulk transfers up to the counter wrap; the final one drops pull_en mid-request.
    while (n_xfer < 255) begin
      rd = DW'($urandom);
      fetch(rd, 0, rd[16:1], 1'b0, "bulk");
    end
    fetch(18'h30000, 2, 16'h8000, 1'b1, "drop");
    check("wrap cnt", 32'(xfer_cnt), 32'd0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (inp_0r !== 1'b0) cnt++;
    end
    check("drop no req", 32'(cnt), 32'd0);
    check("drop idle busy", 32'(busy), 32'd0);

    // Reset in the middle of a request.
    pull_en = 1'b1;
    wait_req(1'b1, "rst req");
    check("rst busy before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst inp_0r", 32'(inp_0r), 32'd0);
    check("rst valid", 32'(out_valid), 32'd0);
    check("rst cnt", 32'(xfer_cnt), 32'd0);
    check("rst err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = '0;
    fetch(18'h1FFFE, 2, 16'hFFFF, 1'b0, "post rst");

`ifdef BRZ_PULL_TIMEOUT_EN
    // Responder never acks: abort after 15 cycles in REQ.
    wait_req(1'b1, "tmo req");
    pull_en = 1'b0;
    cnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (err !== 1'b0) cnt++;
    end
    check("tmo no early err", 32'(cnt), 32'd0);
    @(negedge clk);
    check("tmo err", 32'(err), 32'd1);
    check("tmo inp_0r", 32'(inp_0r), 32'd0);
    check("tmo valid", 32'(out_valid), 32'd0);
    check("tmo cnt", 32'(xfer_cnt), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
